// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and state type for the instruction memory loader
package imem_pkg;

   localparam int IMEM_WIDTH  = 32;
   localparam int IMEM_ADDR_W = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and imem write port bundle for the loader
interface imem_loader_if import imem_pkg::*; #(
   parameter int n = IMEM_WIDTH,
   parameter int r = IMEM_ADDR_W
);

   logic         byte_valid;
   logic [7:0]   byte_data;
   logic         byte_ready;
   logic         imem_we;
   logic [r-1:0] imem_waddr;
   logic [n-1:0] imem_wdata;

   // master is the loader; slave is the byte source plus the imem write port
   modport master (
      input  byte_valid, byte_data,
      output byte_ready, imem_we, imem_waddr, imem_wdata
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, imem_we, imem_waddr, imem_wdata
   );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - big-endian byte shift register with byte counter
module word_assembler import imem_pkg::*; #(
   parameter int n = IMEM_WIDTH
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         shift_en,
   input  logic [7:0]   byte_in,
   output logic [n-1:0] word_out,
   output logic         full
);

   localparam int BPW = n / 8;
   localparam int CW  = $clog2(BPW + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         word_out <= '0;
      end else if (clr) begin
         cnt      <= '0;
      end else if (shift_en) begin
         word_out <= (word_out << 8) | n'(byte_in);
         cnt      <= cnt + CW'(1);
      end
   end

   // Asserted on the shift that brings the count to BPW, so the FSM can leave RECV on that edge
   assign full = shift_en && (cnt == CW'(BPW - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - fills instruction memory from a byte stream, one big-endian word per slot
module imem_loader import imem_pkg::*; #(
   parameter int n = IMEM_WIDTH,
   parameter int r = IMEM_ADDR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [r:0]         len,
   imem_loader_if.master      bus,
   output logic               busy,
   output logic               done
);

   loader_state_t state, state_next;

   logic [r:0]   len_q;
   logic [r-1:0] widx;
   logic [n-1:0] asm_word;
   logic         asm_full;
   logic         asm_clr;
   logic         transfer;
   logic         last_word;

   assign transfer  = (state == RECV) && bus.byte_valid;
   assign last_word = ({1'b0, widx} == (len_q - {{r{1'b0}}, 1'b1}));
   assign asm_clr   = ((state == IDLE) && start) || (state == WRITE);

   word_assembler #(.n(n)) u_asm (
      .clk      (clk),
      .reset    (reset),
      .clr      (asm_clr),
      .shift_en (transfer),
      .byte_in  (bus.byte_data),
      .word_out (asm_word),
      .full     (asm_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (len == '0) ? DONE : RECV;
         RECV:    if (asm_full) state_next = WRITE;
         WRITE:   state_next = last_word ? DONE : RECV;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.byte_ready = (state == RECV);
      bus.imem_we    = (state == WRITE);
      busy           = (state != IDLE);
      done           = (state == DONE);
   end

   // Write address/data are captured on the completing byte and then held until the next word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q          <= '0;
         widx           <= '0;
         bus.imem_waddr <= '0;
         bus.imem_wdata <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            len_q <= len;
            widx  <= '0;
         end else if ((state == WRITE) && !last_word) begin
            widx  <= widx + r'(1);
         end
         if (asm_full) begin
            bus.imem_waddr <= widx;
            bus.imem_wdata <= (asm_word << 8) | n'(bus.byte_data);
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader with a word-level reference model
module tb_imem_loader;
   import imem_pkg::*;

   localparam int N   = 32;
   localparam int R   = 6;
   localparam int BPW = N / 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [R:0]   len;
   logic         busy;
   logic         done;

   imem_loader_if #(.n(N), .r(R)) bus ();

   imem_loader #(.n(N), .r(R)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .len   (len),
      .bus   (bus),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int t0;

   logic [N-1:0] mem [64];
   int           wr_cnt [64];
   logic [R-1:0] wa_q [$];
   logic [N-1:0] wd_q [$];
   int           done_cnt;
   int           done_cyc;

   always @(posedge clk) cyc++;

   // imem write port and done observer
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.imem_we) begin
            mem[bus.imem_waddr] = bus.imem_wdata;
            wr_cnt[bus.imem_waddr]++;
            wa_q.push_back(bus.imem_waddr);
            wd_q.push_back(bus.imem_wdata);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   function automatic logic [N-1:0] pack(input logic [7:0] bs[$], input int k);
      logic [N-1:0] w = '0;
      for (int b = 0; b < BPW; b++) w = w * 256 + N'(bs[k * BPW + b]);
      return w;
   endfunction

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      done_cnt = 0;
      done_cyc = 0;
      for (int a = 0; a < 64; a++) begin
         wr_cnt[a] = 0;
         mem[a] = '0;
      end
   endtask

   task automatic make_bytes(input int cnt, output logic [7:0] q[$]);
      q.delete();
      for (int i = 0; i < cnt; i++) q.push_back(8'($urandom_range(0, 255)));
   endtask

   // Caller sits at a negedge; returns at the negedge after the start edge E0
   task automatic start_load(input int l);
      start = 1'b1;
      len   = (R+1)'(l);
      @(posedge clk);
      #1 t0 = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_bytes(input logic [7:0] bs[$], input int gap, output int retries);
      int   tries;
      logic rdy;
      retries = 0;
      foreach (bs[i]) begin
         if (gap > 0 && i > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         bus.byte_valid = 1'b1;
         bus.byte_data  = bs[i];
         tries = 0;
         do begin
            rdy = bus.byte_ready;
            @(negedge clk);
            tries++;
         end while (!rdy && tries < 100);
         if (!rdy) begin
            n_checks++;
            $display("FAIL byte_accept byte %0d got ready=0 required ready=1", i);
         end
         retries += tries - 1;
      end
      bus.byte_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 300) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL idle_timeout got busy=%b required 0", busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      len   = '0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = '0;
      clear_log();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.byte_ready, bus.imem_we, busy, done} !== 4'b0)
         $display("FAIL reset_ctl got %b required 0000", {bus.byte_ready, bus.imem_we, busy, done});
      else n_pass++;
      n_checks++;
      if (bus.imem_waddr !== '0 || bus.imem_wdata !== '0)
         $display("FAIL reset_bus got %h/%h required 0/0", bus.imem_waddr, bus.imem_wdata);
      else n_pass++;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] bs[$];
      int ret;
      bs = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};
      clear_log();
      start_load(2);
      send_bytes(bs, 0, ret);
      wait_idle();
      n_checks++;
      if (wa_q.size() !== 2) $display("FAIL basic_we_cycles got %0d required 2", wa_q.size());
      else n_pass++;
      for (int k = 0; k < 2 && k < wa_q.size(); k++) begin
         n_checks++;
         if (wa_q[k] !== R'(k) || wd_q[k] !== pack(bs, k))
            $display("FAIL basic_word%0d got %h:%h required %h:%h", k, wa_q[k], wd_q[k], R'(k), pack(bs, k));
         else n_pass++;
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc - t0 !== 2 * (BPW + 1))
         $display("FAIL basic_done got count %0d at %0d required 1 at %0d", done_cnt, done_cyc - t0, 2 * (BPW + 1));
      else n_pass++;
      n_checks++;
      if (ret !== 1) $display("FAIL basic_retries got %0d required 1", ret);
      else n_pass++;
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] bs[$];
      int ret;
      clear_log();
      start_load(1);
      bs = '{8'hAA, 8'hBB};
      send_bytes(bs, 0, ret);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.byte_ready, bus.imem_we, busy, done} !== 4'b0)
         $display("FAIL abort_ctl got %b required 0000", {bus.byte_ready, bus.imem_we, busy, done});
      else n_pass++;
      n_checks++;
      if (bus.imem_waddr !== '0 || bus.imem_wdata !== '0)
         $display("FAIL abort_bus got %h/%h required 0/0", bus.imem_waddr, bus.imem_wdata);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      clear_log();
      bs = '{8'h11, 8'h22, 8'h33, 8'h44};
      start_load(1);
      send_bytes(bs, 0, ret);
      wait_idle();
      n_checks++;
      if (wa_q.size() !== 1 || wa_q[0] !== '0 || wd_q[0] !== 32'h11223344)
         $display("FAIL abort_reload got %0d writes first %h required 1 write 11223344",
                  wa_q.size(), (wd_q.size() > 0) ? wd_q[0] : '0);
      else n_pass++;
      n_checks++;
      if (done_cnt !== 1) $display("FAIL abort_done got %0d required 1", done_cnt);
      else n_pass++;
   endtask

   task automatic test_stalls();
      logic [7:0] bs[$];
      int ret;
      bs = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};
      clear_log();
      start_load(2);
      send_bytes(bs, 3, ret);
      wait_idle();
      n_checks++;
      if (wa_q.size() !== 2) $display("FAIL stall_writes got %0d required 2", wa_q.size());
      else n_pass++;
      for (int k = 0; k < 2 && k < wa_q.size(); k++) begin
         n_checks++;
         if (wa_q[k] !== R'(k) || wd_q[k] !== pack(bs, k))
            $display("FAIL stall_word%0d got %h:%h required %h:%h", k, wa_q[k], wd_q[k], R'(k), pack(bs, k));
         else n_pass++;
      end
      n_checks++;
      if (ret !== 0) $display("FAIL stall_ready_drop got %0d refusals required 0", ret);
      else n_pass++;
   endtask

   task automatic test_len0();
      clear_log();
      start_load(0);
      n_checks++;
      if (done !== 1'b1 || bus.byte_ready !== 1'b0)
         $display("FAIL len0_done got done=%b ready=%b required 1/0", done, bus.byte_ready);
      else n_pass++;
      wait_idle();
      n_checks++;
      if (wa_q.size() !== 0 || done_cnt !== 1)
         $display("FAIL len0_writes got %0d writes %0d dones required 0/1", wa_q.size(), done_cnt);
      else n_pass++;
   endtask

   task automatic test_len64();
      logic [7:0] bs[$];
      int ret;
      int bad = 0;
      make_bytes(64 * BPW, bs);
      clear_log();
      start_load(64);
      send_bytes(bs, 0, ret);
      wait_idle();
      for (int a = 0; a < 64; a++) begin
         n_checks++;
         if (wr_cnt[a] !== 1 || mem[a] !== pack(bs, a)) begin
            $display("FAIL len64_addr%0d got %0d writes data %h required 1 write %h", a, wr_cnt[a], mem[a], pack(bs, a));
            bad++;
         end else n_pass++;
      end
      n_checks++;
      if (wa_q.size() !== 64 || done_cnt !== 1)
         $display("FAIL len64_total got %0d writes %0d dones required 64/1", wa_q.size(), done_cnt);
      else n_pass++;
   endtask

   task automatic test_ignored_start();
      logic [7:0] b1[$];
      logic [7:0] b3[$];
      int ret;
      b1 = '{8'hDE};
      b3 = '{8'hAD, 8'hBE, 8'hEF};
      clear_log();
      start_load(1);
      send_bytes(b1, 0, ret);
      start = 1'b1;
      len   = (R+1)'(5);
      @(negedge clk);
      start = 1'b0;
      send_bytes(b3, 0, ret);
      wait_idle();
      repeat (4) @(negedge clk);
      n_checks++;
      if (wa_q.size() !== 1 || wd_q[0] !== 32'hDEADBEEF)
         $display("FAIL ignstart_writes got %0d writes required 1 of DEADBEEF", wa_q.size());
      else n_pass++;
      n_checks++;
      if (done_cnt !== 1 || busy !== 1'b0)
         $display("FAIL ignstart_done got %0d dones busy=%b required 1/0", done_cnt, busy);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0] bs[$];
      int ret;
      int l;
      int g;
      for (int it = 0; it < 6; it++) begin
         l = $urandom_range(1, 6);
         g = $urandom_range(0, 2);
         make_bytes(l * BPW, bs);
         clear_log();
         start_load(l);
         send_bytes(bs, g, ret);
         wait_idle();
         n_checks++;
         if (wa_q.size() !== l || done_cnt !== 1)
            $display("FAIL rand%0d_count got %0d writes %0d dones required %0d/1", it, wa_q.size(), done_cnt, l);
         else n_pass++;
         for (int k = 0; k < l && k < wa_q.size(); k++) begin
            n_checks++;
            if (wa_q[k] !== R'(k) || wd_q[k] !== pack(bs, k))
               $display("FAIL rand%0d_word%0d got %h:%h required %h:%h", it, k, wa_q[k], wd_q[k], R'(k), pack(bs, k));
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reset_mid_load();
      test_stalls();
      test_len0();
      test_len64();
      test_ignored_start();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills instruction memory before the CPU is released from reset. It accepts a byte stream over a valid/ready handshake and packs bytes big-endian into n-bit words. It writes each completed word into the instruction memory write port at consecutive addresses starting at 0, then pulses done. It sits between the host/UART byte source and the imem write port; the CPU fetch path uses the read port only.

## Interface
Parameters:
- n, 32, word width in bits; must be a multiple of 8 (BPW = n/8 bytes per word)
- r, 6, imem address width (2**r word slots)

Ports:
- clk, input, 1, system clock; all state changes on rising edge
- reset, input, 1, asynchronous, active-high; forces IDLE and clears all outputs
- start, input, 1, begin a load; sampled only in IDLE
- len, input, r+1, number of words to load (0..2**r); sampled with start
- byte_valid, input, 1, source has a byte on byte_data
- byte_data, input, 8, stream byte
- byte_ready, output, 1, loader accepts a byte this cycle
- imem_we, output, 1, write strobe to imem write port
- imem_waddr, output, r, word address for the write
- imem_wdata, output, n, word to write
- busy, output, 1, high in any state other than IDLE
- done, output, 1, one-cycle pulse when a load completes

## Operation
- Reset: every output is 0 (byte_ready, imem_we, imem_waddr, imem_wdata, busy, done); the state is IDLE; the byte and word counters are 0.
- The FSM has four states: IDLE, RECV, WRITE, DONE.
- In IDLE, start=1 latches len and clears the word index.
  - If len=0, go to DONE.
  - Otherwise, go to RECV.
  - start is ignored in all other states.
- In RECV:
  - byte_ready=1.
  - A transfer occurs when byte_valid && byte_ready.
  - Each transfer shifts the byte into the assembler. The first byte lands in bits [n-1:n-8] and the last in [7:0].
  - The transfer that completes BPW bytes moves the FSM to WRITE.
  - byte_valid=0 simply stalls the FSM with no timeout.
- In WRITE:
  - imem_we=1, imem_waddr=word index, imem_wdata=assembled word. All three are held for exactly one cycle.
  - byte_ready=0.
  - If word index == len-1, go to DONE. Otherwise, increment the word index, clear the byte counter, and return to RECV.
- In DONE: done=1 for one cycle, then go to IDLE.
- Valid range of len is 1..2**r. len=2**r writes addresses 0..2**r-1, and the index never wraps past the last address. len>2**r is impossible by width.
- imem_waddr and imem_wdata hold their last values when imem_we=0. Only imem_we qualifies them.
- Reset mid-load aborts immediately. Words already written remain in imem, and no done pulse is produced.
- Bytes presented while byte_ready=0 are not consumed. The source must hold them.

## Timing
- Edge numbering:
  - start is sampled at edge E0; byte_ready is high from the cycle after E0.
  - With byte_valid held high, bytes are accepted at E1..E(BPW).
  - imem_we is high in the cycle after E(BPW), and the word is committed by imem at edge E(BPW+1).
- Per-word cost is BPW+1 cycles minimum (5 for n=32). An L-word load completes in L*(BPW+1) cycles after E0.
- done is high in the cycle after the final WRITE cycle; busy falls in the same cycle that done falls.
- len=0: done is high in the cycle after E0, with no writes and no byte_ready.
- byte_ready is a registered function of state only and has no combinational path from byte_valid.

## Structure
- Shared package imem_pkg:
  - IMEM_WIDTH (32) and IMEM_ADDR_W (6) constants.
  - loader_state_t enum {IDLE, RECV, WRITE, DONE}.
- Sub-module word_assembler:
  - Byte shift register plus byte counter; interface clk, reset, clr, shift_en, byte_in, word_out, full.
  - full asserts when the counter reaches BPW.
- The top module holds the FSM, the word-index counter and the output registers.
- imem gains a synchronous write port (we, waddr, wdata) to which this block connects.

## Test plan
- Reset behaviour: assert reset mid-RECV after 2 bytes → all outputs 0 the same cycle. After release, start len=1 with bytes 11 22 33 44 → single write addr 0 data 11223344, not a stale partial word.
- Basic load: start, len=2, bytes 8C 01 00 04 20 02 00 05 back-to-back → writes addr 0 = 8C010004 and addr 1 = 20020005; imem_we high exactly 2 cycles; done pulses at cycle 10 after E0.
- Stalls: same stream with byte_valid deasserted for 3 cycles between every byte → identical writes, no duplicated or dropped bytes; byte_ready never falls in RECV.
- Edge lengths:
  - len=0 → done the cycle after start, zero writes.
  - len=64 → addresses 0..63 each written once; readback through the imem read port matches the stream.
- Ignored start: pulse start with len=5 during RECV of a len=1 load → only one write occurs; busy drops after the single done pulse.
